mem_stage_rsp: RTL and testbench

//  Next-generation MEM pipeline stage. Sits between EX and WB and accepts the EX->MS bus.

---
 rtl/mem_stage_rsp_pkg.sv | 28 ++
 rtl/mem_stage_rsp_if.sv | 28 ++
 rtl/mem_stage_rsp_load_align.sv | 17 +
 rtl/mem_stage_rsp.sv | 64 ++++++
 tb/tb_mem_stage_rsp.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_rsp_pkg.sv
// mem_stage_rsp_pkg: widths, bus layouts and state codes shared by the MEM stage.
package mem_stage_rsp_pkg;
    localparam int DW = 32;
    localparam int RF_AW = 5;
    localparam int MAX_OUTST = 2;
    localparam int CW = $clog2(MAX_OUTST + 1);
    typedef enum logic [1:0] {MEM_SIZE_B, MEM_SIZE_H, MEM_SIZE_W} mem_size_e;
    typedef enum logic [1:0] {MS_IDLE, MS_WAIT, MS_HOLD} ms_state_e;
    typedef struct packed {
        logic [DW-1:0]    pc;
        logic             load_op;
        mem_size_e        mem_size;
        logic             load_sign;
        logic [1:0]       addr_lo;
        logic             req_issued;
        logic             rf_we;
        logic [RF_AW-1:0] rf_waddr;
        logic [DW-1:0]    alu_result;
    } es2ms_t;
    typedef struct packed {
        logic [DW-1:0]    pc;
        logic             rf_we;
        logic [RF_AW-1:0] rf_waddr;
        logic [DW-1:0]    rf_wdata;
    } ms2ws_t;
    localparam int ES2MS_WD = $bits(es2ms_t);
    localparam int MS2WS_WD = $bits(ms2ws_t);
endpackage

// File: rtl/mem_stage_rsp_if.sv
// mem_stage_rsp_if: EX/WB/SRAM-side signals of the MEM stage; MS_LOAD_FWD_EN adds forwarding to ID.
interface mem_stage_rsp_if;
    import mem_stage_rsp_pkg::*;
    logic             flush;
    logic             ws_allowin;
    logic             ms_allowin;
    logic             es_to_ms_valid;
    es2ms_t           es_to_ms_bus;
    logic             ms_to_ws_valid;
    ms2ws_t           ms_to_ws_bus;
    logic             data_ok;
    logic [DW-1:0]    data_rdata;
    logic             ms_valid;
    logic [RF_AW-1:0] ms_rf_waddr;
`ifdef MS_LOAD_FWD_EN
    logic             ms_fwd_valid;
    logic [DW-1:0]    ms_fwd_data;
    modport master (output flush, ws_allowin, es_to_ms_valid, es_to_ms_bus, data_ok, data_rdata,
                    input ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_valid, ms_rf_waddr, ms_fwd_valid, ms_fwd_data);
    modport slave (input flush, ws_allowin, es_to_ms_valid, es_to_ms_bus, data_ok, data_rdata,
                   output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_valid, ms_rf_waddr, ms_fwd_valid, ms_fwd_data);
`else
    modport master (output flush, ws_allowin, es_to_ms_valid, es_to_ms_bus, data_ok, data_rdata,
                    input ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_valid, ms_rf_waddr);
    modport slave (input flush, ws_allowin, es_to_ms_valid, es_to_ms_bus, data_ok, data_rdata,
                   output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_valid, ms_rf_waddr);
`endif
endinterface

// File: rtl/mem_stage_rsp_load_align.sv
// ms_load_align: selects the byte/half lane of SRAM read data and sign/zero-extends it.
module ms_load_align import mem_stage_rsp_pkg::*; (
    input  logic [DW-1:0] rdata,
    input  logic [1:0]    addr_lo,
    input  mem_size_e     mem_size,
    input  logic          load_sign,
    output logic [DW-1:0] result
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b = rdata[{addr_lo, 3'b000} +: 8];
        h = addr_lo[1] ? rdata[16 +: 16] : rdata[0 +: 16];
        result = mem_size == MEM_SIZE_B ? {{(DW-8){load_sign & b[7]}}, b} :
                 mem_size == MEM_SIZE_H ? {{(DW-16){load_sign & h[15]}}, h} : rdata;
    end
endmodule

// File: rtl/mem_stage_rsp.sv
// mem_stage_rsp: MEM stage waiting on variable-latency SRAM responses, with WB-stall hold and flush drop.
// Optional MS_LOAD_FWD_EN adds ms_fwd_valid/ms_fwd_data towards ID.
module mem_stage_rsp import mem_stage_rsp_pkg::*; (
    input logic clk,
    input logic reset,
    mem_stage_rsp_if.slave ms
);
    ms_state_e     state, state_nx;
    es2ms_t        r;
    logic          valid, rsp, ready_go, allowin, drop_inc, drop_dec;
    logic [CW-1:0] drop_cnt;
    logic [DW-1:0] hold_data, align_data, wdata;

    ms_load_align u_align (
        .rdata    (ms.data_rdata),
        .addr_lo  (r.addr_lo),
        .mem_size (r.mem_size),
        .load_sign(r.load_sign),
        .result   (align_data)
    );

    // A response only belongs to the held instruction once all flushed requests have drained.
    always_comb begin
        rsp = ms.data_ok && drop_cnt == '0;
        ready_go = state != MS_WAIT || rsp;
        allowin = !valid || (ready_go && ms.ws_allowin);
        drop_inc = ms.flush && valid && state == MS_WAIT && !rsp;
        drop_dec = ms.data_ok && drop_cnt != '0;
        wdata = state == MS_HOLD ? hold_data : (r.load_op && r.req_issued) ? align_data : r.alu_result;
        state_nx = ms.flush ? MS_IDLE :
                   allowin ? ((ms.es_to_ms_valid && ms.es_to_ms_bus.req_issued) ? MS_WAIT : MS_IDLE) :
                   (state == MS_WAIT && rsp) ? MS_HOLD : state;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= MS_IDLE;
        else state <= state_nx;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            valid <= 1'b0;
            drop_cnt <= '0;
            hold_data <= '0;
            r <= '0;
        end else begin
            valid <= ms.flush ? 1'b0 : allowin ? ms.es_to_ms_valid : valid;
            if (allowin && ms.es_to_ms_valid) r <= ms.es_to_ms_bus;
            if (state == MS_WAIT && rsp && !ms.ws_allowin) hold_data <= wdata;
            if (drop_inc && !drop_dec && drop_cnt != CW'(MAX_OUTST)) drop_cnt <= drop_cnt + 1'b1;
            else if (drop_dec && !drop_inc) drop_cnt <= drop_cnt - 1'b1;
        end

    assert property (@(posedge clk) disable iff (!reset) !(drop_inc && !drop_dec && drop_cnt == CW'(MAX_OUTST)));

    assign ms.ms_allowin = allowin;
    assign ms.ms_to_ws_valid = valid && ready_go && !ms.flush;
    assign ms.ms_to_ws_bus = {r.pc, r.rf_we, r.rf_waddr, wdata};
    assign ms.ms_valid = valid;
    assign ms.ms_rf_waddr = r.rf_waddr;
`ifdef MS_LOAD_FWD_EN
    assign ms.ms_fwd_valid = valid && ready_go && r.rf_we && !ms.flush;
    assign ms.ms_fwd_data = wdata;
`endif
endmodule

// File: tb/tb_mem_stage_rsp.sv
// tb_mem_stage_rsp: directed and random stimulus checked against a transaction-level model
// that tracks outstanding SRAM requests as a queue of killed flags.
module tb_mem_stage_rsp;
    import mem_stage_rsp_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_stage_rsp_if bus();
    mem_stage_rsp dut (.clk(clk), .reset(reset), .ms(bus));

    int vectors = 0;
    int miscompares = 0;
    bit m_valid = 1'b0;
    bit m_got = 1'b0;
    es2ms_t m_ins = '0;
    logic [31:0] m_held = '0;
    bit kq[$];

    task automatic check(string tag, logic [79:0] got, logic [79:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ld_ref(logic [31:0] d, logic [1:0] a, int sz, bit sgn);
        longint v;
        if (sz == 0) begin
            v = longint'((d >> (8 * a)) & 32'hFF);
            if (sgn && v > 127) v = v - 256;
        end else if (sz == 1) begin
            v = longint'((d >> (16 * (a / 2))) & 32'hFFFF);
            if (sgn && v > 32767) v = v - 65536;
        end else v = longint'(d);
        return v[31:0];
    endfunction

    function automatic es2ms_t mk(bit ld, int sz, bit sg, int a, bit rq, bit we, int wa, logic [31:0] alu);
        es2ms_t e;
        e.pc = $urandom;
        e.load_op = ld;
        e.mem_size = mem_size_e'(sz);
        e.load_sign = sg;
        e.addr_lo = 2'(a);
        e.req_issued = rq;
        e.rf_we = we;
        e.rf_waddr = 5'(wa);
        e.alu_result = alu;
        return e;
    endfunction

    function automatic es2ms_t rand_ins();
        bit ld = 1'($urandom_range(0, 1));
        bit rq = $urandom_range(0, 3) != 0;
        bit we = ld || (!rq && 1'($urandom_range(0, 1)));
        return mk(ld, $urandom_range(0, 2), 1'($urandom_range(0, 1)), $urandom_range(0, 3), rq, we,
                  $urandom_range(0, 31), $urandom);
    endfunction

    task automatic step(bit esv, es2ms_t eb, bit wa, bit fl, bit dok, logic [31:0] rd,
                        output logic [31:0] o_wd, output bit o_vl, output bit o_al);
        bit needs, rsp, ready, allow;
        logic [31:0] wd;
        bus.es_to_ms_valid = esv;
        bus.es_to_ms_bus = eb;
        bus.ws_allowin = wa;
        bus.flush = fl;
        bus.data_ok = dok;
        bus.data_rdata = rd;
        @(negedge clk);
        needs = m_ins.req_issued;
        rsp = dok && kq.size() > 0 && !kq[0];
        ready = m_valid && (!needs || m_got || rsp);
        allow = !m_valid || (ready && wa);
        wd = (!m_ins.load_op || !needs) ? m_ins.alu_result : m_got ? m_held :
             ld_ref(rd, m_ins.addr_lo, int'(m_ins.mem_size), m_ins.load_sign);
        o_wd = bus.ms_to_ws_bus.rf_wdata;
        o_vl = bus.ms_to_ws_valid;
        o_al = bus.ms_allowin;
        check("ms_valid", 80'(bus.ms_valid), 80'(m_valid));
        check("ms_allowin", 80'(bus.ms_allowin), 80'(allow));
        check("to_ws_valid", 80'(bus.ms_to_ws_valid), 80'(ready && !fl));
        if (ready && !fl) check("to_ws_bus", 80'(bus.ms_to_ws_bus), 80'({m_ins.pc, m_ins.rf_we, m_ins.rf_waddr, wd}));
        if (m_valid) check("ms_rf_waddr", 80'(bus.ms_rf_waddr), 80'(m_ins.rf_waddr));
`ifdef MS_LOAD_FWD_EN
        check("fwd_valid", 80'(bus.ms_fwd_valid), 80'(ready && !fl && m_ins.rf_we));
        if (ready && !fl && m_ins.rf_we) check("fwd_data", 80'(bus.ms_fwd_data), 80'(wd));
`endif
        if (dok) void'(kq.pop_front());
        if (rsp && !fl && !wa) begin
            m_got = 1'b1;
            m_held = wd;
        end
        if (fl) begin
            if (m_valid && needs && !m_got && !rsp) kq[kq.size() - 1] = 1'b1;
            m_valid = 1'b0;
        end else if (allow) begin
            m_valid = esv;
            m_got = 1'b0;
            if (esv) begin
                m_ins = eb;
                if (eb.req_issued) kq.push_back(1'b0);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] wd;
        bit vl, al, fl, dok, esv;
        int nk;
        bus.es_to_ms_valid = 1'b0;
        bus.es_to_ms_bus = '0;
        bus.ws_allowin = 1'b0;
        bus.flush = 1'b0;
        bus.data_ok = 1'b0;
        bus.data_rdata = '0;
        @(posedge clk);
        #1;
        check("rst_ms_valid", 80'(bus.ms_valid), 80'(0));
        check("rst_allowin", 80'(bus.ms_allowin), 80'(1));
        check("rst_to_ws_valid", 80'(bus.ms_to_ws_valid), 80'(0));
        reset = 1'b1;
        // ALU result passes straight through
        step(1, mk(0, 2, 0, 0, 0, 1, 3, 32'h1234), 1, 0, 0, 0, wd, vl, al);
        check("alu_wdata", 80'(bus.ms_to_ws_bus.rf_wdata), 80'(32'h1234));
        check("alu_valid", 80'(bus.ms_to_ws_valid), 80'(1));
        step(0, '0, 1, 0, 0, 0, wd, vl, al);
        // signed byte load, response three cycles late
        step(1, mk(1, 0, 1, 2, 1, 1, 5, 0), 1, 0, 0, 0, wd, vl, al);
        for (int i = 0; i < 3; i++) begin
            step(0, '0, 1, 0, 0, 0, wd, vl, al);
            check("lb_stall_allowin", 80'(al), 80'(0));
        end
        step(0, '0, 1, 0, 1, 32'h0080_0000, wd, vl, al);
        check("lb_wdata", 80'(wd), 80'(32'hFFFF_FF80));
        check("lb_valid", 80'(vl), 80'(1));
        // unsigned half load held while WB stalls
        step(1, mk(1, 1, 0, 2, 1, 1, 6, 0), 1, 0, 0, 0, wd, vl, al);
        step(0, '0, 0, 0, 1, 32'hBEEF_0000, wd, vl, al);
        step(0, '0, 0, 0, 0, 32'h1111_1111, wd, vl, al);
        check("lhu_hold_allowin", 80'(al), 80'(0));
        step(0, '0, 1, 0, 0, 32'h2222_2222, wd, vl, al);
        check("lhu_wdata", 80'(wd), 80'(32'h0000_BEEF));
        check("lhu_valid", 80'(vl), 80'(1));
        // flush in WAIT: the stale response is dropped
        step(1, mk(1, 2, 0, 0, 1, 1, 7, 0), 1, 0, 0, 0, wd, vl, al);
        step(0, '0, 1, 1, 0, 0, wd, vl, al);
        step(1, mk(1, 2, 0, 0, 1, 1, 8, 0), 1, 0, 0, 0, wd, vl, al);
        step(0, '0, 1, 0, 1, 32'hDEAD, wd, vl, al);
        check("drop_valid", 80'(vl), 80'(0));
        step(0, '0, 1, 0, 1, 32'h5A5A, wd, vl, al);
        check("after_drop_wdata", 80'(wd), 80'(32'h5A5A));
        check("after_drop_valid", 80'(vl), 80'(1));
        // flush coincident with the response consumes it
        step(1, mk(1, 2, 0, 0, 1, 1, 9, 0), 1, 0, 0, 0, wd, vl, al);
        step(0, '0, 1, 1, 1, 32'h7777, wd, vl, al);
        check("flush_rsp_valid", 80'(vl), 80'(0));
        step(1, mk(1, 2, 0, 0, 1, 1, 10, 0), 1, 0, 0, 0, wd, vl, al);
        step(0, '0, 1, 0, 1, 32'h3C3C, wd, vl, al);
        check("no_drop_valid", 80'(vl), 80'(1));
        check("no_drop_wdata", 80'(wd), 80'(32'h3C3C));
        for (int c = 0; c < 1500; c++) begin
            nk = 0;
            foreach (kq[i]) nk += int'(kq[i]);
            fl = $urandom_range(0, 9) == 0 && nk < MAX_OUTST;
            dok = kq.size() > 0 && $urandom_range(0, 2) == 0;
            esv = !fl && $urandom_range(0, 3) != 0;
            step(esv, rand_ins(), $urandom_range(0, 3) != 0, fl, dok, $urandom, wd, vl, al);
        end
        for (int i = 0; i < 8 && kq.size() > 0; i++) step(0, '0, 1, 0, 1, $urandom, wd, vl, al);
        step(0, '0, 1, 0, 0, 0, wd, vl, al);
        // asynchronous reset while holding a response
        step(1, mk(1, 2, 0, 0, 1, 1, 11, 0), 1, 0, 0, 0, wd, vl, al);
        step(0, '0, 0, 0, 1, 32'h9999, wd, vl, al);
        #2;
        reset = 1'b0;
        #1;
        check("areset_ms_valid", 80'(bus.ms_valid), 80'(0));
        check("areset_allowin", 80'(bus.ms_allowin), 80'(1));
        check("areset_to_ws_valid", 80'(bus.ms_to_ws_valid), 80'(0));
        m_valid = 1'b0;
        m_got = 1'b0;
        kq.delete();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        step(1, mk(0, 2, 0, 0, 0, 1, 12, 32'hCAFE), 1, 0, 0, 0, wd, vl, al);
        step(0, '0, 1, 0, 0, 0, wd, vl, al);
        check("post_reset_wdata", 80'(wd), 80'(32'hCAFE));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
